// File: rtl/gusn_pkg.sv
// Shared fixed-point helpers and FSM state type for the LAYER / loss_stage datapath.
// Values travel sign-extended to MAXW bits and are clamped back to the caller's width w (w <= 31).
package gusn_pkg;

    localparam int unsigned MAXW = 32;

    typedef logic signed [MAXW-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RUN
    } state_e;

    function automatic wide_t max_pos(input int unsigned w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t max_neg(input int unsigned w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    function automatic wide_t clamp_w(input wide_t x, input int unsigned w);
        if (x > max_pos(w)) return max_pos(w);
        if (x < max_neg(w)) return max_neg(w);
        return x;
    endfunction

    // Operands are already width-w values, so the exact sum/difference never overflows MAXW.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
        return clamp_w(a + b, w);
    endfunction

    function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int unsigned w);
        return clamp_w(a - b, w);
    endfunction

    // Clamped ReLU: 0 below zero, 1.0 (1 << frac) above one.
    function automatic wide_t relu_clamp(input wide_t x, input int unsigned frac);
        if (x < 0) return '0;
        if (x > (wide_t'(1) <<< frac)) return wide_t'(1) <<< frac;
        return x;
    endfunction

    function automatic logic relu_clamp_grad(input wide_t x, input int unsigned frac);
        return (x > 0) && (x < (wide_t'(1) <<< frac));
    endfunction

endpackage

// File: rtl/loss_stage.sv
// Terminal loss stage: serially forms err = out - target, drives err >>> GRAD_SHIFT as the
// backprop seed and accumulates a saturating squared-error loss through the shared multiplier.
module loss_stage
    import gusn_pkg::*;
#(
    parameter int unsigned INT_W      = 8,
    parameter int unsigned FRAC_W     = 8,
    parameter int unsigned OUTPUTS    = 1,
    parameter int unsigned GRAD_SHIFT = 0,
    parameter int unsigned NUM_W      = INT_W + FRAC_W
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     enable,
    input  logic [OUTPUTS*NUM_W-1:0] inputs_f,
    input  logic [OUTPUTS*NUM_W-1:0] targets,
    output logic [OUTPUTS*NUM_W-1:0] output_b,
    output logic [NUM_W-1:0]         loss,
    output logic                     mult_en,
    output logic [NUM_W-1:0]         mult_v1,
    output logic [NUM_W-1:0]         mult_v2,
    output logic                     mult_shift,
    input  logic [NUM_W-1:0]         mult_res,
    input  logic                     ready_f_in,
    output logic                     ready_out,
    input  logic                     start,
    output logic                     done
);

    localparam int unsigned      CNT_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUTPUTS - 1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [OUTPUTS*NUM_W-1:0]   ob_q, ob_d;
    logic [NUM_W-1:0]           loss_q, loss_d;
    logic                       done_q, done_d;

    logic [NUM_W-1:0]           in_sel, tg_sel;
    logic signed [NUM_W-1:0]    err, err_scaled;
    logic [NUM_W-1:0]           loss_sum;

    always_comb begin
        in_sel = '0;
        tg_sel = '0;
        for (int unsigned i = 0; i < OUTPUTS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                in_sel = inputs_f[i*NUM_W +: NUM_W];
                tg_sel = targets[i*NUM_W +: NUM_W];
            end
        end
    end

    assign err        = NUM_W'(sat_sub(wide_t'(signed'(in_sel)), wide_t'(signed'(tg_sel)), NUM_W));
    assign err_scaled = err >>> GRAD_SHIFT;
    assign loss_sum   = NUM_W'(sat_add(wide_t'(signed'(loss_q)), wide_t'(signed'(mult_res)), NUM_W));

    // Holding every register at its current value by default makes enable=0 a full freeze.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ob_d    = ob_q;
        loss_d  = loss_q;
        done_d  = done_q;
        if (enable) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        ob_d    = '0;
                        loss_d  = '0;
                    end
                end
                WAIT: begin
                    if (ready_f_in) state_d = RUN;
                end
                RUN: begin
                    for (int unsigned i = 0; i < OUTPUTS; i++) begin
                        if (cnt_q == CNT_W'(i)) ob_d[i*NUM_W +: NUM_W] = err_scaled;
                    end
                    loss_d = loss_sum;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ob_q    <= '0;
            loss_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ob_q    <= ob_d;
            loss_q  <= loss_d;
            done_q  <= done_d;
        end
    end

    assign mult_en    = (state_q == RUN);
    assign mult_v1    = mult_en ? err : '0;
    assign mult_v2    = mult_en ? err : '0;
    assign mult_shift = 1'b0;
    assign ready_out  = (state_q == IDLE);
    assign output_b   = ob_q;
    assign loss       = loss_q;
    assign done       = done_q;

endmodule
